// File: rtl/axis_frame_arb_mux.sv
// rtl/axis_frame_arb_mux.sv - four-source round-robin frame arbiter feeding one registered stream output
module axis_frame_arb_mux #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] input_0_axis_tdata,
   input  logic                  input_0_axis_tvalid,
   output logic                  input_0_axis_tready,
   input  logic                  input_0_axis_tlast,
   input  logic                  input_0_axis_tuser,
   input  logic [DATA_WIDTH-1:0] input_1_axis_tdata,
   input  logic                  input_1_axis_tvalid,
   output logic                  input_1_axis_tready,
   input  logic                  input_1_axis_tlast,
   input  logic                  input_1_axis_tuser,
   input  logic [DATA_WIDTH-1:0] input_2_axis_tdata,
   input  logic                  input_2_axis_tvalid,
   output logic                  input_2_axis_tready,
   input  logic                  input_2_axis_tlast,
   input  logic                  input_2_axis_tuser,
   input  logic [DATA_WIDTH-1:0] input_3_axis_tdata,
   input  logic                  input_3_axis_tvalid,
   output logic                  input_3_axis_tready,
   input  logic                  input_3_axis_tlast,
   input  logic                  input_3_axis_tuser,
   output logic [DATA_WIDTH-1:0] output_axis_tdata,
   output logic                  output_axis_tvalid,
   input  logic                  output_axis_tready,
   output logic                  output_axis_tlast,
   output logic                  output_axis_tuser,
   output logic [1:0]            grant_port,
   output logic                  busy
);

   typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

   state_t                state_q;
   logic [1:0]            rr_ptr_q;
   logic [1:0]            grant_q;
   logic [DATA_WIDTH-1:0] out_tdata_q;
   logic                  out_tvalid_q;
   logic                  out_tlast_q;
   logic                  out_tuser_q;

   logic [DATA_WIDTH-1:0] in_tdata [4];
   logic [3:0]            in_tvalid;
   logic [3:0]            in_tlast;
   logic [3:0]            in_tuser;

   logic [1:0]            grant_d;
   logic [1:0]            scan_idx;
   logic                  scan_found;
   logic                  out_ready;
   logic                  gnt_ready;
   logic                  xfer;

   assign in_tdata[0] = input_0_axis_tdata;
   assign in_tdata[1] = input_1_axis_tdata;
   assign in_tdata[2] = input_2_axis_tdata;
   assign in_tdata[3] = input_3_axis_tdata;
   assign in_tvalid   = {input_3_axis_tvalid, input_2_axis_tvalid, input_1_axis_tvalid, input_0_axis_tvalid};
   assign in_tlast    = {input_3_axis_tlast,  input_2_axis_tlast,  input_1_axis_tlast,  input_0_axis_tlast};
   assign in_tuser    = {input_3_axis_tuser,  input_2_axis_tuser,  input_1_axis_tuser,  input_0_axis_tuser};

   // Round-robin pick: first requesting source at or after rr_ptr, wrapping modulo 4
   always_comb begin
      grant_d    = rr_ptr_q;
      scan_idx   = rr_ptr_q;
      scan_found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         scan_idx = rr_ptr_q + 2'(i);
         if (!scan_found && in_tvalid[scan_idx]) begin
            scan_found = 1'b1;
            grant_d    = scan_idx;
         end
      end
   end

   // The output register can accept a beat when empty or when its current beat is being taken
   assign out_ready = output_axis_tready | ~out_tvalid_q;
   assign gnt_ready = (state_q == ACTIVE) & out_ready;
   assign xfer      = gnt_ready & in_tvalid[grant_q];

   assign input_0_axis_tready = gnt_ready & (grant_q == 2'd0);
   assign input_1_axis_tready = gnt_ready & (grant_q == 2'd1);
   assign input_2_axis_tready = gnt_ready & (grant_q == 2'd2);
   assign input_3_axis_tready = gnt_ready & (grant_q == 2'd3);

   assign output_axis_tdata  = out_tdata_q;
   assign output_axis_tvalid = out_tvalid_q;
   assign output_axis_tlast  = out_tlast_q;
   assign output_axis_tuser  = out_tuser_q;
   assign grant_port         = grant_q;
   assign busy               = (state_q == ACTIVE);

   // Grant FSM plus output register; a tlast transfer closes the frame and rotates priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= 2'd0;
         grant_q      <= 2'd0;
         out_tdata_q  <= '0;
         out_tvalid_q <= 1'b0;
         out_tlast_q  <= 1'b0;
         out_tuser_q  <= 1'b0;
      end else begin
         if (xfer) begin
            out_tdata_q  <= in_tdata[grant_q];
            out_tlast_q  <= in_tlast[grant_q];
            out_tuser_q  <= in_tuser[grant_q];
            out_tvalid_q <= 1'b1;
         end else if (out_ready) begin
            out_tvalid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (|in_tvalid) begin
                  grant_q <= grant_d;
                  state_q <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (xfer && in_tlast[grant_q]) begin
                  state_q  <= IDLE;
                  rr_ptr_q <= grant_q + 2'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_frame_arb_mux.sv
// tb/tb_axis_frame_arb_mux.sv - directed checks of frame arbitration, latency, backpressure, gaps and reset
module tb_axis_frame_arb_mux;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dat [4];
   logic [3:0] vld = 4'b0;
   logic [3:0] lst = 4'b0;
   logic [3:0] usr = 4'b0;
   wire  [3:0] rdy;
   logic       out_tready = 1'b1;
   wire  [7:0] out_tdata;
   wire        out_tvalid;
   wire        out_tlast;
   wire        out_tuser;
   wire  [1:0] grant_port;
   wire        busy;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // source model: per-source beat memory {user,last,data}, read position, optional gap
   logic [9:0]  src_mem [4][32];
   int          src_len [4];
   int          src_pos [4];
   int          gap_at  [4];
   int          gap_len [4];
   int          start_cyc [4];
   logic [11:0] cap     [64];
   int          cap_cyc [64];
   int          cap_n = 0;

   axis_frame_arb_mux #(.DATA_WIDTH(8)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .input_0_axis_tdata  (dat[0]), .input_0_axis_tvalid (vld[0]), .input_0_axis_tready (rdy[0]),
      .input_0_axis_tlast  (lst[0]), .input_0_axis_tuser  (usr[0]),
      .input_1_axis_tdata  (dat[1]), .input_1_axis_tvalid (vld[1]), .input_1_axis_tready (rdy[1]),
      .input_1_axis_tlast  (lst[1]), .input_1_axis_tuser  (usr[1]),
      .input_2_axis_tdata  (dat[2]), .input_2_axis_tvalid (vld[2]), .input_2_axis_tready (rdy[2]),
      .input_2_axis_tlast  (lst[2]), .input_2_axis_tuser  (usr[2]),
      .input_3_axis_tdata  (dat[3]), .input_3_axis_tvalid (vld[3]), .input_3_axis_tready (rdy[3]),
      .input_3_axis_tlast  (lst[3]), .input_3_axis_tuser  (usr[3]),
      .output_axis_tdata   (out_tdata),
      .output_axis_tvalid  (out_tvalid),
      .output_axis_tready  (out_tready),
      .output_axis_tlast   (out_tlast),
      .output_axis_tuser   (out_tuser),
      .grant_port          (grant_port),
      .busy                (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] mk(input logic [1:0] g, input logic u, input logic l, input logic [7:0] d);
      return {g, u, l, d};
   endfunction

   task automatic push(input int s, input logic [7:0] d, input logic l, input logic u);
      src_mem[s][src_len[s]] = {u, l, d};
      src_len[s]++;
   endtask

   task automatic wait_caps(input int n);
      int t;
      t = 0;
      while (cap_n < n && t < 300) begin
         @(posedge clk); #2;
         t++;
      end
      chk("wait_caps", 32'(cap_n >= n), 32'd1);
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   // source drivers and output monitor: handshakes judged at negedge, inputs advanced 1 after posedge
   initial begin : driver
      logic [3:0] fire;
      logic       nv;
      for (int i = 0; i < 4; i++) begin
         dat[i] = 8'h00; src_len[i] = 0; src_pos[i] = 0;
         gap_at[i] = -1; gap_len[i] = 0; start_cyc[i] = 0;
      end
      forever begin
         @(negedge clk);
         fire = vld & rdy;
         if (!rst && out_tvalid && out_tready && cap_n < 64) begin
            cap[cap_n]     = {grant_port, out_tuser, out_tlast, out_tdata};
            cap_cyc[cap_n] = cyc;
            cap_n++;
         end
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) begin
            if (fire[i] && src_pos[i] < src_len[i]) src_pos[i]++;
            nv = 1'b0;
            if (src_pos[i] < src_len[i]) begin
               if (src_pos[i] == gap_at[i] && gap_len[i] > 0) gap_len[i]--;
               else nv = 1'b1;
            end
            if (nv && !vld[i]) start_cyc[i] = cyc;
            vld[i] = nv;
            if (nv) {usr[i], lst[i], dat[i]} = src_mem[i][src_pos[i]];
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      int b;
      int g;

      // reset state
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_tvalid", out_tvalid, 0);
      chk("rst_tdata", out_tdata, 0);
      chk("rst_tlast", out_tlast, 0);
      chk("rst_tuser", out_tuser, 0);
      chk("rst_grant", grant_port, 0);
      chk("rst_tready", rdy, 0);

      // single 3-beat frame on source 2, latency 2 then one beat per cycle
      @(posedge clk); #2;
      b = cap_n;
      push(2, 8'h11, 0, 0); push(2, 8'h22, 0, 1); push(2, 8'h33, 1, 0);
      wait_caps(b + 3);
      chk("t1_b0", cap[b],     mk(2, 0, 0, 8'h11));
      chk("t1_b1", cap[b + 1], mk(2, 1, 0, 8'h22));
      chk("t1_b2", cap[b + 2], mk(2, 0, 1, 8'h33));
      chk("t1_lat0", cap_cyc[b]     - start_cyc[2], 2);
      chk("t1_lat1", cap_cyc[b + 1] - start_cyc[2], 3);
      chk("t1_lat2", cap_cyc[b + 2] - start_cyc[2], 4);
      tick(2);
      @(negedge clk);
      chk("t1_idle_busy", busy, 0);
      chk("t1_hold_grant", grant_port, 2);

      // fresh reset, all four sources at once: order 0..3, one dead cycle between frames
      @(posedge clk); #2; rst = 1'b1;
      @(posedge clk); #2; rst = 1'b0;
      b = cap_n;
      for (int i = 0; i < 4; i++) begin
         push(i, 8'(i * 16 + 1), 0, i == 3);
         push(i, 8'(i * 16 + 2), 1, i == 3);
      end
      wait_caps(b + 8);
      for (int i = 0; i < 4; i++) begin
         chk("t2_first", cap[b + 2 * i],     mk(2'(i), i == 3, 0, 8'(i * 16 + 1)));
         chk("t2_last",  cap[b + 2 * i + 1], mk(2'(i), i == 3, 1, 8'(i * 16 + 2)));
         chk("t2_cyc_a", cap_cyc[b + 2 * i]     - start_cyc[0], 2 + 3 * i);
         chk("t2_cyc_b", cap_cyc[b + 2 * i + 1] - start_cyc[0], 3 + 3 * i);
      end
      tick(3);

      // move rr_ptr to 2 with a one-beat frame on source 1, then 1 and 3 request continuously
      b = cap_n;
      push(1, 8'h40, 1, 0);
      wait_caps(b + 1);
      tick(3);
      push(3, 8'h50, 1, 0); push(3, 8'h51, 1, 0);
      push(1, 8'h60, 0, 0); push(1, 8'h61, 1, 0);
      push(1, 8'h62, 0, 0); push(1, 8'h63, 1, 0);
      wait_caps(b + 7);
      chk("t3_0", cap[b],     mk(1, 0, 1, 8'h40));
      chk("t3_1", cap[b + 1], mk(3, 0, 1, 8'h50));
      chk("t3_2", cap[b + 2], mk(1, 0, 0, 8'h60));
      chk("t3_3", cap[b + 3], mk(1, 0, 1, 8'h61));
      chk("t3_4", cap[b + 4], mk(3, 0, 1, 8'h51));
      chk("t3_5", cap[b + 5], mk(1, 0, 0, 8'h62));
      chk("t3_6", cap[b + 6], mk(1, 0, 1, 8'h63));
      tick(3);

      // backpressure for 5 cycles after the first beat of a 4-beat frame on source 0
      b = cap_n;
      push(0, 8'hC0, 0, 0); push(0, 8'hC1, 0, 0); push(0, 8'hC2, 0, 1); push(0, 8'hC3, 1, 0);
      wait_caps(b + 1);
      out_tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_hold_valid", out_tvalid, 1);
         chk("t4_hold_data", out_tdata, 8'hC1);
         chk("t4_src_ready", rdy[0], 0);
      end
      @(posedge clk); #2; out_tready = 1'b1;
      wait_caps(b + 4);
      tick(4);
      chk("t4_count", cap_n - b, 4);
      chk("t4_b0", cap[b],     mk(0, 0, 0, 8'hC0));
      chk("t4_b1", cap[b + 1], mk(0, 0, 0, 8'hC1));
      chk("t4_b2", cap[b + 2], mk(0, 1, 0, 8'hC2));
      chk("t4_b3", cap[b + 3], mk(0, 0, 1, 8'hC3));

      // source 2 drops tvalid for 4 cycles mid-frame while source 0 waits
      b = cap_n;
      g = src_len[2] + 2;
      gap_at[2] = g; gap_len[2] = 4;
      push(2, 8'hD0, 0, 0); push(2, 8'hD1, 0, 0); push(2, 8'hD2, 0, 0); push(2, 8'hD3, 1, 0);
      push(0, 8'hE0, 1, 1);
      for (int t = 0; t < 100; t++) begin
         @(posedge clk); #2;
         if (src_pos[2] == g && !vld[2]) break;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t5_gap_seen", vld[2], 0);
      chk("t5_gap_busy", busy, 1);
      chk("t5_gap_grant", grant_port, 2);
      chk("t5_src0_wait", rdy[0], 0);
      wait_caps(b + 5);
      chk("t5_0", cap[b],     mk(2, 0, 0, 8'hD0));
      chk("t5_1", cap[b + 1], mk(2, 0, 0, 8'hD1));
      chk("t5_2", cap[b + 2], mk(2, 0, 0, 8'hD2));
      chk("t5_3", cap[b + 3], mk(2, 0, 1, 8'hD3));
      chk("t5_4", cap[b + 4], mk(0, 1, 1, 8'hE0));
      tick(3);

      // reset after 2 of 4 beats on source 1; nothing more of it, next grant from rr_ptr=0
      b = cap_n;
      push(1, 8'hF0, 0, 0); push(1, 8'hF1, 0, 0); push(1, 8'hF2, 0, 0); push(1, 8'hF3, 1, 0);
      wait_caps(b + 2);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) src_pos[i] = src_len[i];
      @(posedge clk); #2;
      @(negedge clk);
      chk("t6_tvalid", out_tvalid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_grant", grant_port, 0);
      chk("t6_tready", rdy, 0);
      @(posedge clk); #2; rst = 1'b0;
      push(3, 8'h70, 1, 0);
      push(0, 8'h80, 1, 0);
      wait_caps(b + 4);
      tick(4);
      chk("t6_count", cap_n - b, 4);
      chk("t6_f0", cap[b],     mk(1, 0, 0, 8'hF0));
      chk("t6_f1", cap[b + 1], mk(1, 0, 0, 8'hF1));
      chk("t6_first", cap[b + 2], mk(0, 0, 1, 8'h80));
      chk("t6_second", cap[b + 3], mk(3, 0, 1, 8'h70));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
